// File: rtl/issueq_free_tracker_if.sv
// Issue-queue free tracker bundle: grant/flush inputs,
// free-list write ports and status outputs.
interface issueq_free_tracker_if #(
  parameter int SIZE_ISSUEQ = 32,
  parameter int ISSUE_WIDTH = 4,
  parameter int FREE_PORTS  = 4,
  parameter int IDX_W       = $clog2(SIZE_ISSUEQ)
);
  logic [ISSUE_WIDTH-1:0]       grantedValid_i;
  logic [ISSUE_WIDTH*IDX_W-1:0] grantedId_i;
  logic [SIZE_ISSUEQ-1:0]       flushVec_i;
  logic [FREE_PORTS-1:0]        freePortEnable_i;
  logic                         freeReady_i;
  logic [FREE_PORTS-1:0]        freedValid_o;
  logic [FREE_PORTS*IDX_W-1:0]  freedId_o;
  logic [IDX_W:0]               pendingCount_o;
  logic                         grantDupErr_o;

  modport master (
    output grantedValid_i, grantedId_i, flushVec_i,
    output freePortEnable_i, freeReady_i,
    input  freedValid_o, freedId_o, pendingCount_o,
    input  grantDupErr_o
  );

  modport slave (
    input  grantedValid_i, grantedId_i, flushVec_i,
    input  freePortEnable_i, freeReady_i,
    output freedValid_o, freedId_o, pendingCount_o,
    output grantDupErr_o
  );
endinterface

// File: rtl/issueq_free_tracker.sv
// Issue-queue entry reclaimer: tracks granted/flushed entries
// and returns one per block per cycle to the free list.
module issueq_free_tracker #(
  parameter int SIZE_ISSUEQ = 32,
  parameter int ISSUE_WIDTH = 4,
  parameter int FREE_PORTS  = 4,
  parameter int IDX_W       = $clog2(SIZE_ISSUEQ)
) (
  input logic clk,
  input logic reset_n,
  issueq_free_tracker_if.slave bus
);
  localparam int EPB  = SIZE_ISSUEQ / FREE_PORTS;
  localparam int LAST = SIZE_ISSUEQ - (FREE_PORTS-1)*EPB;
  localparam int PW   = (LAST > 1) ? $clog2(LAST) : 1;

  function automatic int bsz(int p);
    return (p == FREE_PORTS-1) ? LAST : EPB;
  endfunction

  logic [SIZE_ISSUEQ-1:0] pend_q, pend_d;
  logic [SIZE_ISSUEQ-1:0] set_vec, clr_vec;
  logic [PW-1:0]          ptr_q [FREE_PORTS];
  logic [PW-1:0]          ptr_d [FREE_PORTS];
  logic [PW-1:0]          sel_off [FREE_PORTS];
  logic [FREE_PORTS-1:0]  sel_v, fv;
  logic [FREE_PORTS*IDX_W-1:0] fid;
  logic [IDX_W-1:0]       gid [ISSUE_WIDTH];
  logic [IDX_W:0]         cnt;
  logic                   dup_q, dup_d;

  // First pending bit at or after the pointer, wrapping in-block
  always_comb begin
    for (int p = 0; p < FREE_PORTS; p++) begin
      sel_v[p]   = 1'b0;
      sel_off[p] = '0;
      for (int k = 0; k < LAST; k++) begin
        int off;
        off = int'(ptr_q[p]) + k;
        if (off >= bsz(p)) off = off - bsz(p);
        if (k < bsz(p) && !sel_v[p] &&
            pend_q[p*EPB + off]) begin
          sel_v[p]   = 1'b1;
          sel_off[p] = PW'(off);
        end
      end
    end
  end

  always_comb begin
    fid     = '0;
    clr_vec = '0;
    for (int p = 0; p < FREE_PORTS; p++) begin
      fv[p] = sel_v[p] & bus.freePortEnable_i[p]
            & bus.freeReady_i & reset_n;
      ptr_d[p] = ptr_q[p];
      if (fv[p]) begin
        fid[p*IDX_W +: IDX_W] =
          IDX_W'(p*EPB + int'(sel_off[p]));
        clr_vec[p*EPB + int'(sel_off[p])] = 1'b1;
        if (int'(sel_off[p]) + 1 == bsz(p))
          ptr_d[p] = '0;
        else
          ptr_d[p] = sel_off[p] + PW'(1);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < ISSUE_WIDTH; k++)
      gid[k] = bus.grantedId_i[k*IDX_W +: IDX_W];
  end

  always_comb begin
    set_vec = bus.flushVec_i;
    dup_d   = dup_q;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      if (bus.grantedValid_i[k] &&
          int'(gid[k]) < SIZE_ISSUEQ) begin
        set_vec[gid[k]] = 1'b1;
        if (pend_q[gid[k]]) dup_d = 1'b1;
        for (int j = 0; j < k; j++)
          if (bus.grantedValid_i[j] && gid[j] == gid[k])
            dup_d = 1'b1;
      end
    end
  end

  // Set beats clear so a regrant of a freed entry stays pending
  assign pend_d = set_vec | (pend_q & ~clr_vec);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < SIZE_ISSUEQ; i++)
      cnt = cnt + (IDX_W+1)'(pend_q[i]);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_q <= '0;
      dup_q  <= 1'b0;
      for (int p = 0; p < FREE_PORTS; p++)
        ptr_q[p] <= '0;
    end else begin
      pend_q <= pend_d;
      dup_q  <= dup_d;
      for (int p = 0; p < FREE_PORTS; p++)
        ptr_q[p] <= ptr_d[p];
    end
  end

  assign bus.freedValid_o   = fv;
  assign bus.freedId_o      = fid;
  assign bus.pendingCount_o = cnt;
  assign bus.grantDupErr_o  = dup_q;
endmodule

// File: tb/tb_issueq_free_tracker.sv
// Self-checking bench for issueq_free_tracker: default 32-entry
// instance plus a 30-entry instance for the uneven last block.
module tb_issueq_free_tracker;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  issueq_free_tracker_if #(.SIZE_ISSUEQ(32)) b1 ();
  issueq_free_tracker_if #(.SIZE_ISSUEQ(30)) b2 ();

  issueq_free_tracker #(.SIZE_ISSUEQ(32)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(b1)
  );
  issueq_free_tracker #(.SIZE_ISSUEQ(30)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(b2)
  );

  typedef struct {
    logic [3:0]  gv;
    logic [19:0] gid;
    logic [31:0] fl;
    logic [3:0]  en;
    logic        rdy;
  } stim_t;

  typedef struct {
    logic [3:0]  v;
    logic [19:0] id;
    logic [5:0]  cnt;
    logic        dup;
  } exp_t;

  exp_t sb[$];
  int vecs = 0;
  int errs = 0;

  function automatic logic [19:0] pk(int a0, int a1,
                                     int a2, int a3);
    return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  function automatic stim_t st(logic [3:0] gv,
      logic [19:0] gid, logic [31:0] fl,
      logic [3:0] en, logic rdy);
    stim_t s;
    s.gv = gv; s.gid = gid; s.fl = fl;
    s.en = en; s.rdy = rdy;
    return s;
  endfunction

  function automatic exp_t ex(logic [3:0] v,
      logic [19:0] id, int cnt, logic dup);
    exp_t e;
    e.v = v; e.id = id; e.cnt = 6'(cnt); e.dup = dup;
    return e;
  endfunction

  task automatic drive1(input stim_t s);
    b1.grantedValid_i   = s.gv;
    b1.grantedId_i      = s.gid;
    b1.flushVec_i       = s.fl;
    b1.freePortEnable_i = s.en;
    b1.freeReady_i      = s.rdy;
  endtask

  task automatic drive2(input stim_t s);
    b2.grantedValid_i   = s.gv;
    b2.grantedId_i      = s.gid;
    b2.flushVec_i       = s.fl[29:0];
    b2.freePortEnable_i = s.en;
    b2.freeReady_i      = s.rdy;
  endtask

  task automatic test_reset();
    stim_t s;
    exp_t e;
    s = st(4'b0001, pk(5,0,0,0), 32'hFFFF_FFFF, 4'hF, 1'b1);
    reset_n = 1'b0;
    drive1(s);
    drive2(s);
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        reset_n = 1'b1;
        s = st(4'b0, '0, '0, 4'hF, 1'b1);
        drive1(s);
        drive2(s);
      end
      sb.push_back(ex(4'b0, '0, 0, 1'b0));
      sb.push_back(ex(4'b0, '0, 0, 1'b0));
      #1;
      e = sb.pop_front();
      vecs++;
      if ({b1.freedValid_o, b1.freedId_o, b1.pendingCount_o,
           b1.grantDupErr_o} !== {e.v, e.id, e.cnt, e.dup}) begin
        errs++;
        $display("FAIL reset[%0d] dut1: got v=%b id=%h cnt=%0d dup=%b want v=%b id=%h cnt=%0d dup=%b",
          c, b1.freedValid_o, b1.freedId_o, b1.pendingCount_o,
          b1.grantDupErr_o, e.v, e.id, e.cnt, e.dup);
      end
      e = sb.pop_front();
      vecs++;
      if ({b2.freedValid_o, b2.freedId_o, b2.pendingCount_o,
           b2.grantDupErr_o} !== {e.v, e.id, e.cnt, e.dup}) begin
        errs++;
        $display("FAIL reset[%0d] dut2: got v=%b id=%h cnt=%0d dup=%b want v=%b id=%h cnt=%0d dup=%b",
          c, b2.freedValid_o, b2.freedId_o, b2.pendingCount_o,
          b2.grantDupErr_o, e.v, e.id, e.cnt, e.dup);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run1(input string nm, input stim_t s[$],
                      input exp_t x[$]);
    exp_t e;
    foreach (s[i]) begin
      drive1(s[i]);
      sb.push_back(x[i]);
      #1;
      e = sb.pop_front();
      vecs++;
      if ({b1.freedValid_o, b1.freedId_o, b1.pendingCount_o,
           b1.grantDupErr_o} !== {e.v, e.id, e.cnt, e.dup}) begin
        errs++;
        $display("FAIL %s[%0d]: got v=%b id=%h cnt=%0d dup=%b want v=%b id=%h cnt=%0d dup=%b",
          nm, i, b1.freedValid_o, b1.freedId_o,
          b1.pendingCount_o, b1.grantDupErr_o,
          e.v, e.id, e.cnt, e.dup);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_basic();
    stim_t s[$];
    exp_t x[$];
    s.push_back(st(4'b0011, pk(3,9,0,0), '0, 4'hF, 1'b1));
    x.push_back(ex(4'b0, '0, 0, 1'b0));
    s.push_back(st(4'b0, '0, '0, 4'hF, 1'b1));
    x.push_back(ex(4'b0011, pk(3,9,0,0), 2, 1'b0));
    s.push_back(st(4'b0, '0, '0, 4'hF, 1'b1));
    x.push_back(ex(4'b0, '0, 0, 1'b0));
    run1("basic", s, x);
  endtask

  task automatic test_round_robin();
    stim_t s[$];
    exp_t x[$];
    // free id 7 first so the block-0 pointer wraps to 0
    s.push_back(st(4'b0001, pk(7,0,0,0), '0, 4'hF, 1'b1));
    x.push_back(ex(4'b0, '0, 0, 1'b0));
    s.push_back(st(4'b0, '0, '0, 4'hF, 1'b1));
    x.push_back(ex(4'b0001, pk(7,0,0,0), 1, 1'b0));
    s.push_back(st(4'b0011, pk(1,5,0,0), '0, 4'hF, 1'b1));
    x.push_back(ex(4'b0, '0, 0, 1'b0));
    s.push_back(st(4'b0001, pk(1,0,0,0), '0, 4'hF, 1'b1));
    x.push_back(ex(4'b0001, pk(1,0,0,0), 2, 1'b0));
    s.push_back(st(4'b0, '0, '0, 4'hF, 1'b1));
    x.push_back(ex(4'b0001, pk(5,0,0,0), 2, 1'b1));
    s.push_back(st(4'b0, '0, '0, 4'hF, 1'b1));
    x.push_back(ex(4'b0001, pk(1,0,0,0), 1, 1'b1));
    s.push_back(st(4'b0, '0, '0, 4'hF, 1'b1));
    x.push_back(ex(4'b0, '0, 0, 1'b1));
    run1("round_robin", s, x);
  endtask

  task automatic test_backpressure();
    stim_t s[$];
    exp_t x[$];
    s.push_back(st(4'hF, pk(0,8,16,24), '0, 4'hF, 1'b1));
    x.push_back(ex(4'b0, '0, 0, 1'b1));
    s.push_back(st(4'b0, '0, '0, 4'hF, 1'b0));
    x.push_back(ex(4'b0, '0, 4, 1'b1));
    s.push_back(st(4'b0, '0, '0, 4'hF, 1'b0));
    x.push_back(ex(4'b0, '0, 4, 1'b1));
    s.push_back(st(4'b0, '0, '0, 4'b0101, 1'b1));
    x.push_back(ex(4'b0101, pk(0,0,16,0), 4, 1'b1));
    s.push_back(st(4'b0, '0, '0, 4'b0101, 1'b1));
    x.push_back(ex(4'b0, '0, 2, 1'b1));
    s.push_back(st(4'b0, '0, '0, 4'hF, 1'b1));
    x.push_back(ex(4'b1010, pk(0,8,0,24), 2, 1'b1));
    run1("backpressure", s, x);
  endtask

  task automatic test_flush_drain();
    stim_t s[$];
    exp_t x[$];
    int off;
    s.push_back(st(4'b0, '0, 32'hFFFF_FFFF, 4'hF, 1'b1));
    x.push_back(ex(4'b0, '0, 0, 1'b1));
    // every pointer sits at offset 1 after the previous test
    for (int k = 0; k < 8; k++) begin
      off = (1 + k) % 8;
      s.push_back(st(4'b0, '0, '0, 4'hF, 1'b1));
      x.push_back(ex(4'hF, pk(off, 8+off, 16+off, 24+off),
                     32 - 4*k, 1'b1));
    end
    s.push_back(st(4'b0, '0, '0, 4'hF, 1'b1));
    x.push_back(ex(4'b0, '0, 0, 1'b1));
    run1("flush_drain", s, x);
  endtask

  task automatic test_dup_nondiv();
    stim_t s[$];
    exp_t x[$];
    exp_t e;
    s.push_back(st(4'b0011, pk(29,31,0,0), '0, 4'hF, 1'b1));
    x.push_back(ex(4'b0, '0, 0, 1'b0));
    s.push_back(st(4'b0, '0, '0, 4'hF, 1'b1));
    x.push_back(ex(4'b1000, pk(0,0,0,29), 1, 1'b0));
    s.push_back(st(4'b0001, pk(7,0,0,0), '0, 4'hF, 1'b1));
    x.push_back(ex(4'b0, '0, 0, 1'b0));
    s.push_back(st(4'b0001, pk(7,0,0,0), '0, 4'hF, 1'b0));
    x.push_back(ex(4'b0, '0, 1, 1'b0));
    s.push_back(st(4'b0, '0, '0, 4'hF, 1'b1));
    x.push_back(ex(4'b0010, pk(0,7,0,0), 1, 1'b1));
    s.push_back(st(4'b0, '0, '0, 4'hF, 1'b1));
    x.push_back(ex(4'b0, '0, 0, 1'b1));
    foreach (s[i]) begin
      drive2(s[i]);
      sb.push_back(x[i]);
      #1;
      e = sb.pop_front();
      vecs++;
      if ({b2.freedValid_o, b2.freedId_o, b2.pendingCount_o,
           b2.grantDupErr_o} !== {e.v, e.id, e.cnt, e.dup}) begin
        errs++;
        $display("FAIL dup_nondiv[%0d]: got v=%b id=%h cnt=%0d dup=%b want v=%b id=%h cnt=%0d dup=%b",
          i, b2.freedValid_o, b2.freedId_o,
          b2.pendingCount_o, b2.grantDupErr_o,
          e.v, e.id, e.cnt, e.dup);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_flush_drain();
    test_dup_nondiv();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end
endmodule
